// File: rtl/peak_group_tracker.sv
// -----------------------------------------------------------------------------
// peak_group_tracker
//
// Extremum filter for the IoT data-filtering datapath. Wide unsigned samples
// are assembled MSB-first from a narrow serial bus. The extreme (max or min)
// of every group of GROUP_N samples is found. That group extreme is reported
// only when it beats the running peak that is held across groups.
//
// Parameters
//   DATA_W   sample width in bits; must be an integer multiple of BUS_W
//   BUS_W    serial bus width; one beat carries BUS_W bits
//   GROUP_N  samples per group (>= 1)
//
// Ports
//   clk        single clock, rising edge
//   rst        synchronous, active-high reset
//   in_valid   beat qualifier
//   in_data    BUS_W-bit sample slice; the first beat of a sample is its MSB slice
//   mode       0 = track maximum, 1 = track minimum; taken on the first beat
//              of each group
//   peak_clr   synchronous clear of the peak and of any partial group
//   out_valid  one-cycle pulse: a new peak was accepted
//   out_data   the peak value while out_valid = 1, otherwise all-zero
//
// Build option
//   PEAK_TIE_REPORT_EN : when defined, a group extreme equal to the current
//   valid peak (same mode) also pulses out_valid with out_data = peak. The
//   peak itself is unchanged. When undefined, ties are silent.
// -----------------------------------------------------------------------------
module peak_group_tracker #(
   parameter int DATA_W  = 128,
   parameter int BUS_W   = 8,
   parameter int GROUP_N = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [BUS_W-1:0]  in_data,
   input  logic              mode,
   input  logic              peak_clr,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data
);

   localparam int BEATS  = DATA_W / BUS_W;
   localparam int BCNT_W = (BEATS   > 1) ? $clog2(BEATS)   : 1;
   localparam int SCNT_W = (GROUP_N > 1) ? $clog2(GROUP_N) : 1;

   // Returns 1 when a is strictly better than b in the given mode.
   // Both values are compared as unsigned numbers.
   function automatic logic is_better(input logic [DATA_W-1:0] a,
                                      input logic [DATA_W-1:0] b,
                                      input logic              m);
      return m ? (a < b) : (a > b);
   endfunction

   // ---------------------------------------------------------------------------
   // Counters and beat qualification
   // ---------------------------------------------------------------------------
   logic [BCNT_W-1:0] beat_cnt;
   logic [SCNT_W-1:0] samp_cnt;

   logic take;          // a beat that is actually consumed
   logic last_beat;
   logic last_samp;
   logic grp_first;     // beat 0 of sample 0
   logic grp_done;      // the final beat of the group is consumed this cycle

   // A beat that coincides with peak_clr is dropped.
   assign take      = in_valid && !peak_clr;
   assign last_beat = (beat_cnt == BCNT_W'(BEATS - 1));
   assign last_samp = (samp_cnt == SCNT_W'(GROUP_N - 1));
   assign grp_first = (beat_cnt == '0) && (samp_cnt == '0);
   assign grp_done  = take && last_beat && last_samp;

   always_ff @(posedge clk) begin
      if (rst || peak_clr) begin
         beat_cnt <= '0;
         samp_cnt <= '0;
      end else if (in_valid) begin
         if (last_beat) begin
            beat_cnt <= '0;
            if (last_samp) samp_cnt <= '0;
            else           samp_cnt <= samp_cnt + SCNT_W'(1);
         end else begin
            beat_cnt <= beat_cnt + BCNT_W'(1);
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Sample assembly
   // ---------------------------------------------------------------------------
   logic [DATA_W-1:0] sample_w;   // full sample, meaningful on the last beat

   generate
      if (BEATS == 1) begin : g_one_beat
         assign sample_w = in_data;
      end else begin : g_shift
         // Only the older DATA_W-BUS_W bits are kept. The newest slice always
         // comes straight from in_data.
         logic [DATA_W-BUS_W-1:0] shift_q;

         assign sample_w = {shift_q, in_data};

         always_ff @(posedge clk) begin
            if (rst || peak_clr)
               shift_q <= '0;
            else if (in_valid)
               shift_q <= sample_w[DATA_W-BUS_W-1:0];
         end
      end
   endgenerate

   // ---------------------------------------------------------------------------
   // Group extreme and group mode
   // ---------------------------------------------------------------------------
   logic              grp_mode;
   logic [DATA_W-1:0] grp_ext;
   logic              cur_mode;
   logic [DATA_W-1:0] new_ext;

   // On the first beat of a group, grp_mode has not been loaded yet. The live
   // mode input is used instead. This matters when BEATS = 1 and GROUP_N = 1.
   assign cur_mode = grp_first ? mode : grp_mode;

   // The first sample of a group always loads. Later samples replace the
   // extreme only when they are strictly better.
   assign new_ext = ((samp_cnt == '0) || is_better(sample_w, grp_ext, cur_mode))
                    ? sample_w : grp_ext;

   always_ff @(posedge clk) begin
      if (rst) begin
         grp_mode <= 1'b0;
      end else if (take && grp_first) begin
         grp_mode <= mode;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || peak_clr) begin
         grp_ext <= '0;
      end else if (take && last_beat) begin
         grp_ext <= new_ext;
      end
   end

   // ---------------------------------------------------------------------------
   // Stage 1: capture the finished group
   // ---------------------------------------------------------------------------
   logic              s1_pend;
   logic              s1_mode;
   logic [DATA_W-1:0] s1_ext;

   always_ff @(posedge clk) begin
      if (rst || peak_clr) begin
         s1_pend <= 1'b0;
         s1_mode <= 1'b0;
         s1_ext  <= '0;
      end else begin
         s1_pend <= grp_done;
         if (grp_done) begin
            s1_mode <= cur_mode;
            s1_ext  <= new_ext;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Stage 2: compare against the running peak and report
   // ---------------------------------------------------------------------------
   logic              peak_vld;
   logic              peak_mode;
   logic [DATA_W-1:0] peak;

   logic              reload;   // peak empty, or the tracking mode changed
   logic              improve;  // strictly better in the same mode
   logic              tie;

   assign reload  = !peak_vld || (peak_mode != s1_mode);
   assign improve = is_better(s1_ext, peak, s1_mode);
   assign tie     = (s1_ext == peak);

   always_ff @(posedge clk) begin
      if (rst || peak_clr) begin
         peak      <= '0;
         peak_vld  <= 1'b0;
         peak_mode <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         out_valid <= 1'b0;
         out_data  <= '0;
         if (s1_pend) begin
            if (reload || improve) begin
               peak      <= s1_ext;
               peak_vld  <= 1'b1;
               peak_mode <= s1_mode;
               out_valid <= 1'b1;
               out_data  <= s1_ext;
            end
`ifdef PEAK_TIE_REPORT_EN
            else if (tie) begin
               out_valid <= 1'b1;
               out_data  <= peak;
            end
`endif
         end
      end
   end

`ifndef PEAK_TIE_REPORT_EN
   // Ties have no effect in this build. The signal is kept so both builds
   // share the same compare logic.
   logic unused_tie;
   assign unused_tie = tie;
`endif

endmodule

// File: tb/tb_peak_group_tracker.sv
// Directed bench for peak_group_tracker with DATA_W=16, BUS_W=8, GROUP_N=4.
module tb_peak_group_tracker;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = '0;
   logic        mode = 1'b0;
   logic        peak_clr = 1'b0;
   logic        out_valid;
   logic [15:0] out_data;

   int n_cmp = 0;
   int n_bad = 0;

   int          pulses = 0;
   int          bad_zero = 0;
   logic [15:0] last_data = '0;

   peak_group_tracker #(.DATA_W(16), .BUS_W(8), .GROUP_N(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .mode      (mode),
      .peak_clr  (peak_clr),
      .out_valid (out_valid),
      .out_data  (out_data)
   );

   always #5 clk = ~clk;

   // Count report pulses on the falling edge. Also flag any nonzero out_data
   // that appears outside a pulse.
   always @(negedge clk) begin
      if (out_valid) begin
         pulses    <= pulses + 1;
         last_data <= out_data;
      end else if (out_data != '0 && !rst) begin
         bad_zero  <= bad_zero + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic drive_beat(input logic [7:0] d, input logic m, input logic clr);
      in_valid = 1'b1;
      in_data  = d;
      mode     = m;
      peak_clr = clr;
      @(posedge clk); #1;
      in_valid = 1'b0;
      peak_clr = 1'b0;
   endtask

   // Sends one full group. The first beat carries mode m. With tog set, mode
   // flips on every later beat and gap cycle, and that must have no effect.
   // Up to gap idle cycles are placed between beats.
   task automatic run_group(input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] c, input logic [15:0] d,
                            input logic m, input int gap, input bit tog);
      logic [15:0] s [4];
      logic        md;
      s[0] = a; s[1] = b; s[2] = c; s[3] = d;
      md = m;
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 2; j++) begin
            if (!(i == 0 && j == 0)) begin
               if (tog) md = ~md;
               mode = md;
               if (gap > 0) idle($urandom_range(0, gap));
            end
            drive_beat(j == 0 ? s[i][15:8] : s[i][7:0],
                       (i == 0 && j == 0) ? m : md, 1'b0);
         end
      end
   endtask

   // Runs a group, waits for the result, and checks the number of pulses
   // and, if one is expected, the reported value.
   task automatic group_chk(input string tag,
                            input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] c, input logic [15:0] d,
                            input logic m, input int gap, input bit tog,
                            input int exp_p, input logic [15:0] exp_d);
      int p0;
      p0 = pulses;
      run_group(a, b, c, d, m, gap, tog);
      idle(4);
      chk({tag, "_cnt"}, pulses - p0, exp_p);
      if (exp_p != 0) chk({tag, "_data"}, {16'h0, last_data}, {16'h0, exp_d});
   endtask

   initial begin
      int p0;
      // Reset
      idle(2);
      chk("rst_valid", {31'h0, out_valid}, 32'h0);
      chk("rst_data", {16'h0, out_data}, 32'h0);
      rst = 1'b0;
      idle(1);

      // Group A: exact latency check. The last beat is edge k.
      p0 = pulses;
      run_group(16'h0010, 16'h0300, 16'h0200, 16'h0001, 1'b0, 0, 1'b0);
      chk("lat_k", {31'h0, out_valid}, 32'h0);
      idle(1);
      chk("lat_k1_valid", {31'h0, out_valid}, 32'h1);
      chk("lat_k1_data", {16'h0, out_data}, 32'h0300);
      idle(1);
      chk("lat_k2_valid", {31'h0, out_valid}, 32'h0);
      chk("lat_k2_data", {16'h0, out_data}, 32'h0);
      idle(2);
      chk("a_cnt", pulses - p0, 1);

      // Max tracking: one group below the peak, then one above it.
      group_chk("b_below", 16'h0100, 16'h0250, 16'h0001, 16'h0200, 1'b0, 0, 1'b0, 0, 16'h0);
      group_chk("c_above", 16'h0400, 16'h0003, 16'h0399, 16'h0100, 1'b0, 0, 1'b0, 1, 16'h0400);

      // A group max equal to the peak.
`ifdef PEAK_TIE_REPORT_EN
      group_chk("d_tie", 16'h0010, 16'h0400, 16'h0020, 16'h0030, 1'b0, 0, 1'b0, 1, 16'h0400);
`else
      group_chk("d_tie", 16'h0010, 16'h0400, 16'h0020, 16'h0030, 1'b0, 0, 1'b0, 0, 16'h0);
`endif

      // Switch to min: the mode mismatch forces a reload. Then a worse min.
      group_chk("e_minload", 16'h0500, 16'h0005, 16'h0100, 16'h0006, 1'b1, 0, 1'b0, 1, 16'h0005);
      group_chk("f_minworse", 16'h0100, 16'h0009, 16'h0050, 16'h0200, 1'b1, 0, 1'b0, 0, 16'h0);

      // peak_clr mid-group, in the same cycle as beat 3. That beat is dropped.
      p0 = pulses;
      drive_beat(8'h0a, 1'b1, 1'b0);
      drive_beat(8'haa, 1'b1, 1'b0);
      drive_beat(8'h00, 1'b1, 1'b0);
      drive_beat(8'h01, 1'b1, 1'b1);
      idle(4);
      chk("clr_quiet", pulses - p0, 0);
      // This would be silent against peak 0x0005. It reports only because
      // the peak was cleared.
      group_chk("g_afterclr", 16'h0800, 16'h0700, 16'h0900, 16'h0750, 1'b1, 0, 1'b0, 1, 16'h0700);

      // peak_clr in the cycle where stage 2 would report: the report is discarded.
      p0 = pulses;
      run_group(16'h0600, 16'h0100, 16'h0300, 16'h0200, 1'b1, 0, 1'b0);
      peak_clr = 1'b1;
      idle(1);
      peak_clr = 1'b0;
      chk("pend_drop_valid", {31'h0, out_valid}, 32'h0);
      idle(3);
      chk("pend_drop_cnt", pulses - p0, 0);
      group_chk("i_firstpeak", 16'h0900, 16'h0950, 16'h0990, 16'h0999, 1'b1, 0, 1'b0, 1, 16'h0900);

      // Random gaps, with mode toggling inside the group.
      group_chk("j_gap_max", 16'h1000, 16'h2000, 16'h1fff, 16'h0001, 1'b0, 3, 1'b1, 1, 16'h2000);
      group_chk("k_gap_max", 16'h1111, 16'h2222, 16'h3333, 16'h0444, 1'b0, 3, 1'b1, 1, 16'h3333);
      group_chk("l_gap_worse", 16'h0100, 16'h2fff, 16'h0200, 16'h0300, 1'b0, 3, 1'b1, 0, 16'h0);
      group_chk("m_gap_min", 16'h5000, 16'h0123, 16'h4000, 16'h0200, 1'b1, 3, 1'b1, 1, 16'h0123);

      idle(1);
      chk("data_zero_idle", bad_zero, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
